mem_arbiter: RTL
================

# mem_arbiter

Sequencer and two-port arbiter for the shared 16-bit SRAM. It serializes fixed-latency read/write transactions from the CPU port (driven by the ISDU/MAR/MDR path) and a loader port (switch/debug memory loader). It sits between both requesters and the SRAM pins. It owns all SRAM strobes, so the ISDU wait-state chains become a single req/ack handshake.

## Interface
- ADDR_W, 16, address width for both ports and the SRAM.
- DATA_W, 16, data width.
- WAIT_CYCLES, 4, SRAM strobe hold cycles per access; legal range ≥1.
- Clk  in  1  single system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-low; Reset=0 at a rising edge resets the block.
- cpu_req  in  1  CPU transaction request; held until cpu_ack.
- cpu_we  in  1  1=write, 0=read; sampled at grant.
- cpu_addr  in  ADDR_W  CPU address; sampled at grant.
- cpu_wdata  in  DATA_W  CPU write data; sampled at grant.
- cpu_rdata  out  DATA_W  last CPU read data; registered, held until next CPU read.
- cpu_ack  out  1  one-cycle completion pulse.
- ld_req, ld_we, ld_addr, ld_wdata, ld_rdata, ld_ack  same directions and widths as the CPU set, loader port.
- sram_addr  out  ADDR_W  latched transaction address.
- sram_wdata  out  DATA_W  latched write data.
- sram_rdata  in  DATA_W  SRAM read data.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.
- busy  out  1  high in ACCESS and DONE.
- grant_cpu  out  1  1 when the current or last transaction belongs to the CPU.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req is high, pick a winner, then latch addr, we and wdata into sram_addr, sram_wdata and an internal we_q. Load the wait counter with WAIT_CYCLES-1, set grant_cpu, and go to ACCESS. With no req, stay in IDLE.
- ACCESS: sram_ce_n=0. sram_oe_n=0 if read, else sram_we_n=0. The counter decrements each cycle. When the counter equals 0, a read captures sram_rdata into the winner's rdata register, and the FSM goes to DONE.
- DONE: all strobes deasserted. The winner's ack=1 for exactly this cycle. The next state is IDLE unconditionally.
- Arbitration with the macro undefined uses fixed priority: CPU beats loader on a tie.
- The loser's req is simply held. It is granted in a later IDLE cycle and is never dropped.
- Counter width is $clog2(WAIT_CYCLES)+1. There is no wrap-around; the counter is only reloaded in IDLE.
- Address, data and we are frozen from grant through DONE. Input changes after grant have no effect on the transaction.
- Protocol violation (req dropped mid-transaction): the access completes and ack still pulses.
- sram_we_n and sram_oe_n are never low in the same cycle.
- No combinational path exists from any input to any output. All outputs are decoded from registers only.

## Timing
- Reset values: sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_addr=0, sram_wdata=0, cpu_rdata=0, ld_rdata=0, cpu_ack=0, ld_ack=0, busy=0, grant_cpu=0; state IDLE.
- Reset asserted mid-transaction: on the next edge, strobes go high and acks go low, and no ack is issued for the aborted access.
- Request seen in IDLE at cycle 0 gives ACCESS in cycles 1..WAIT_CYCLES, with DONE and ack in cycle WAIT_CYCLES+1.
- rdata is valid in the ack cycle.
- Requester handshake: the requester samples ack at the edge ending DONE and deasserts or changes req on that edge.
- Per-transaction throughput is WAIT_CYCLES+2 cycles. There is at least one IDLE cycle between transactions.
- A transaction of length WAIT_CYCLES=1 has exactly one strobe cycle.

## Configuration
- MEM_ARB_RR_EN defined: on a tie, grant the port not granted last.
  - A last-grant register is updated at each grant.
  - It resets to "loader", so the first tie goes to CPU.
  - No port waits more than one transaction behind the other.
- Undefined: fixed CPU priority; no last-grant register.

## Test plan
- Reset, then CPU write addr=0x0010 data=0xBEEF, WAIT_CYCLES=4 -> sram_we_n low cycles 1–4 with sram_addr=0x0010 and sram_wdata=0xBEEF; cpu_ack high in cycle 5 only; sram_oe_n stays high throughout.
- CPU read 0x0010 with sram_rdata model returning 0xBEEF -> sram_oe_n low cycles 1–4; cpu_rdata=0xBEEF when cpu_ack=1 in cycle 5; ld_rdata stays 0.
- cpu_req and ld_req both raised in the same cycle, repeated 3 times, macro undefined -> order CPU,CPU,CPU while loader waits. Macro defined -> order CPU,loader,CPU,loader.
- Loader write 0x1234→0x0020 with cpu_addr toggling during ACCESS -> sram_addr stays 0x0020 throughout; ld_ack one pulse; grant_cpu=0.
- Reset driven low in ACCESS cycle 2 -> next edge all strobes high, busy=0, no ack pulse; a new CPU request afterwards completes normally in 6 cycles.
- WAIT_CYCLES=1 build, CPU read -> one strobe cycle and ack in cycle 2.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (CPU / loader) sequencer for the shared SRAM: one fixed-latency access at a time.
// Define MEM_ARB_RR_EN to alternate grants on a tie; otherwise the CPU always wins a tie.
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              busy,
  output logic              grant_cpu
);
  localparam int CW = $clog2(WAIT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic          any_req, pick_cpu, prio_cpu;

  assign any_req  = cpu_req | ld_req;
  assign pick_cpu = cpu_req & (~ld_req | prio_cpu);

`ifdef MEM_ARB_RR_EN
  // Starts as "loader" so the first tie goes to the CPU.
  logic last_cpu;
  assign prio_cpu = ~last_cpu;
  always_ff @(posedge Clk) begin
    if (!Reset)                     last_cpu <= 1'b0;
    else if (state == IDLE && any_req) last_cpu <= pick_cpu;
  end
`else
  assign prio_cpu = 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction fields are frozen from grant until the next IDLE grant.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt        <= '0;
      we_q       <= 1'b0;
      grant_cpu  <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      cpu_rdata  <= '0;
      ld_rdata   <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        grant_cpu  <= pick_cpu;
        we_q       <= pick_cpu ? cpu_we    : ld_we;
        sram_addr  <= pick_cpu ? cpu_addr  : ld_addr;
        sram_wdata <= pick_cpu ? cpu_wdata : ld_wdata;
        cnt        <= CW'(WAIT_CYCLES - 1);
      end
      if (state == ACCESS) begin
        if (cnt == '0) begin
          if (!we_q) begin
            if (grant_cpu) cpu_rdata <= sram_rdata;
            else           ld_rdata  <= sram_rdata;
          end
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  always_comb begin
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    if (state == ACCESS) begin
      sram_ce_n = 1'b0;
      sram_oe_n = we_q;
      sram_we_n = ~we_q;
    end
    cpu_ack = (state == DONE) &  grant_cpu;
    ld_ack  = (state == DONE) & ~grant_cpu;
    busy    = (state != IDLE);
  end
endmodule
